// File: rtl/dmem_access_sched.sv
// dmem_access_sched: issues the D-memory read/write slot stream for every
// decoding iteration. Each cycle in RUN issues one slot (layer 0 addresses
// 0..NCYC-1, then layer 1 addresses 0..NCYC-1). The write for a slot follows
// its read by WR_DLY cycles through a valid shift register.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; term flag held clear
// RUN   | one slot per cycle on rd_address/rd_layer, rd_en from iteration 1
// DRAIN | no new slots; waiting for the write pipeline to empty
// DONE  | single-cycle completion, done pulsed
module dmem_access_sched #(
    parameter int ADDRESSWIDTH = 5,
    parameter int NCYC         = 20,
    parameter int WR_DLY       = 6,
    parameter int IW           = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [IW-1:0]           max_iter,
    input  logic                    term_req,
    output logic                    rd_en,
    output logic [ADDRESSWIDTH-1:0] rd_address,
    output logic                    rd_layer,
    output logic                    wr_en,
    output logic                    first_iter,
    output logic [IW-1:0]           iter_cnt,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(NCYC - 1);

    state_t                  state, state_n;
    logic                    term_flag, term_flag_n;
    logic [IW-1:0]           last_iter, last_iter_n;
    logic [WR_DLY-1:0]       wr_pipe, wr_pipe_n;
    logic [WR_DLY-1:0]       pipe_tail;

    logic                    rd_en_n;
    logic [ADDRESSWIDTH-1:0] rd_address_n;
    logic                    rd_layer_n;
    logic                    first_iter_n;
    logic [IW-1:0]           iter_cnt_n;
    logic                    busy_n;
    logic                    done_n;

    logic                    term_now;
    logic                    end_of_layer;
    logic                    final_slot;

    // The oldest pipeline bit is driving wr_en this cycle; any other set bit
    // means a write is still pending behind it.
    assign pipe_tail = wr_pipe << 1;
    assign wr_en     = wr_pipe[WR_DLY-1];

    // Next-state, next-slot and registered-output computation.
    always_comb begin
        state_n      = state;
        term_flag_n  = term_flag;
        last_iter_n  = last_iter;
        iter_cnt_n   = iter_cnt;
        rd_en_n      = 1'b0;
        rd_address_n = '0;
        rd_layer_n   = 1'b0;
        done_n       = 1'b0;
        term_now     = term_flag | term_req;
        end_of_layer = (rd_address == LAST_ADDR);
        final_slot   = end_of_layer && rd_layer && (iter_cnt == last_iter);

        // Every cycle spent in RUN has issued exactly one slot.
        wr_pipe_n = (wr_pipe << 1) | WR_DLY'(state == S_RUN);

        case (state)
            S_IDLE: begin
                term_flag_n = 1'b0;
                if (start) begin
                    state_n     = S_RUN;
                    iter_cnt_n  = '0;
                    // max_iter of 0 runs a single iteration
                    last_iter_n = (max_iter == '0) ? '0 : (max_iter - IW'(1));
                end
            end
            S_RUN: begin
                term_flag_n = term_now;
                if (end_of_layer && (final_slot || term_now)) begin
                    state_n = S_DRAIN;
                end else if (end_of_layer) begin
                    rd_layer_n = ~rd_layer;
                    if (rd_layer) begin
                        iter_cnt_n = iter_cnt + IW'(1);
                    end
                    rd_en_n = (iter_cnt_n != '0);
                end else begin
                    rd_address_n = rd_address + ADDRESSWIDTH'(1);
                    rd_layer_n   = rd_layer;
                    rd_en_n      = (iter_cnt != '0);
                end
            end
            S_DRAIN: begin
                if (pipe_tail == '0) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        first_iter_n = (state_n == S_RUN) && (iter_cnt_n == '0);
        busy_n       = (state_n != S_IDLE);
    end

    // State, control and output registers; reset drops everything including
    // in-flight writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            term_flag  <= 1'b0;
            last_iter  <= '0;
            wr_pipe    <= '0;
            rd_en      <= 1'b0;
            rd_address <= '0;
            rd_layer   <= 1'b0;
            first_iter <= 1'b0;
            iter_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            term_flag  <= term_flag_n;
            last_iter  <= last_iter_n;
            wr_pipe    <= wr_pipe_n;
            rd_en      <= rd_en_n;
            rd_address <= rd_address_n;
            rd_layer   <= rd_layer_n;
            first_iter <= first_iter_n;
            iter_cnt   <= iter_cnt_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: doc/dmem_access_sched.md
# dmem_access_sched

Access sequencer for the shift-register-queue D memory: the per-row relative difference of extrinsic messages between iterations, both layers, all 16 circulants. It produces the `rd_en`/`rd_address`/`rd_layer`/`wr_en` slot stream the D memory expects, across all decoding iterations. Write slots are delayed behind read slots to match the row-processing pipeline. It sits between the decoder top-level control (start, iteration limit, early termination) and the D memory.

## Interface
- `ADDRESSWIDTH`, 5, width of the slot address.
- `NCYC`, 20, slots per layer (ceil(Z/P)); must be at least 2 and at most 2^ADDRESSWIDTH.
- `WR_DLY`, 6, cycles from a slot's read issue to its write; must be at least 1.
- `IW`, 4, width of the iteration count.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle start request; honoured only in IDLE.
- `max_iter` in IW: iteration limit, sampled at start. A value of 0 is treated as 1.
- `term_req` in 1: early-termination request (syndrome satisfied). Sampled in RUN only.
- `rd_en` out 1: D-memory read enable.
- `rd_address` out ADDRESSWIDTH: slot address within the layer.
- `rd_layer` out 1: layer of the current slot (0/1).
- `wr_en` out 1: D-memory write enable (queue push; the memory has no write address).
- `first_iter` out 1: high while iteration-0 slots are being issued.
- `iter_cnt` out IW: index of the iteration currently issuing.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- States and transitions:
  - IDLE → RUN on `start`.
  - RUN → DRAIN after the final slot is issued.
  - DRAIN → DONE when the write pipeline is empty.
  - DONE → IDLE after one cycle.
- **Slot order in RUN:** exactly one slot per cycle, no gaps.
  - Within an iteration: layer 0, addresses 0..NCYC-1, then layer 1, addresses 0..NCYC-1.
  - `iter_cnt` increments after the slot (layer 1, NCYC-1).
- **Read enable:** `rd_en` = 1 on a slot only when `iter_cnt` ≥ 1; iteration 0 has no stored D.
  - `rd_address` and `rd_layer` are driven for every slot regardless of `rd_en`.
  - Outside RUN, `rd_address` = 0, `rd_layer` = 0 and `rd_en` = 0.
- **Write pipeline:** a WR_DLY-deep valid shift register is fed 1 for each issued slot and 0 otherwise; its output is `wr_en`.
  - Every issued slot produces exactly one `wr_en`, in slot order, including slots issued in iteration 0.
- **Final slot:** the slot (layer 1, NCYC-1) of iteration eff_max-1, where eff_max = max(`max_iter`, 1).
- **Early termination:** `term_req` high in any RUN cycle sets a sticky flag.
  - The current layer is completed: the last slot issued is address NCYC-1 of the current layer.
  - The state then moves to DRAIN. The flag clears in IDLE.
  - `term_req` arriving in the same cycle as the final slot has no extra effect.
- **Ignored inputs:** `start` outside IDLE and `term_req` outside RUN are ignored.
- **Counter lifetime:** `iter_cnt` clears to 0 when `start` is accepted. It holds its last issuing value through DRAIN, DONE and IDLE.
- **`first_iter`:** equals (state == RUN && `iter_cnt` == 0).
- **Reset:** `rst` in any state, including mid-RUN or mid-DRAIN, takes effect on the next edge.
  - State goes to IDLE and all outputs become 0.
  - The write pipeline is cleared, so no pending `wr_en` leaks out.
  - The term flag clears and `done` is not pulsed.

## Timing
- All outputs are registered; reset value of every output is 0.
- Cycle numbering: `start` sampled high in IDLE at cycle 0.
  - Slot s (counted from 0) appears on the `rd_*` outputs in cycle 1+s.
  - Its `wr_en` appears in cycle 1+s+WR_DLY.
- For final slot index F:
  - RUN spans cycles 1..1+F.
  - DRAIN spans cycles 2+F..1+F+WR_DLY.
  - DONE, with `done`=1, is cycle 2+F+WR_DLY.
  - `busy` is high over cycles 1..2+F+WR_DLY.
- A new `start` is accepted in the cycle after DONE at the earliest.

## Test plan
- **Full run:** NCYC=20, WR_DLY=6, `max_iter`=2, `start` in cycle 0.
  - `rd_en` high in cycles 41..80 only.
  - `rd_layer` 0 in cycles 1..20 and 41..60, and 1 in cycles 21..40 and 61..80.
  - `wr_en` high in cycles 7..86 (80 pulses).
  - `done` in cycle 87; `busy` high in cycles 1..87; `iter_cnt`=1 after completion.
- **Early termination:** `max_iter`=5, `term_req` pulsed in cycle 10.
  - Slots stop after cycle 20 (layer 0, address 19); `rd_en` never asserts.
  - `wr_en` high in cycles 7..26; `done` in cycle 27; `iter_cnt`=0.
- **Termination in layer 1 of iteration 1:** `max_iter`=5, `term_req` in cycle 65.
  - Last slot is in cycle 80; `done` in cycle 87.
- **`max_iter`=0:** behaves as 1.
  - 40 slots, `rd_en` never high, 40 `wr_en` pulses, `done` in cycle 47.
- **Reset mid-run:** `rst` high in cycle 50 of the full-run case.
  - From cycle 51 all outputs are 0, no `wr_en` pulses, no `done`.
  - `start` in cycle 52 restarts from layer 0, address 0, in cycle 53 with `iter_cnt`=0.
- **Restart and ignored start:** `start` re-pulsed in cycle 30 is ignored. `start` in cycle 88, the first cycle after DONE, is accepted.
